// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared types and defaults for the on-chip RAM arbiter between the HPS master
// (m0) and the fabric sample sequencer (m1).
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

endpackage

// File: rtl/onchip_memory_arbiter_arb2_grant.sv
// Pure two-way grant function: one-hot grant from requests, the previous
// winner and the lock state. Holds no state of its own.
module arb2_grant
  import onchip_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       lock_valid,
  input  master_id_t lock_owner,
  input  logic       mode,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (lock_valid) begin
      grant = (lock_owner == M1) ? {req[1], 1'b0} : {1'b0, req[0]};
    end else if (&req) begin
      // Contest: fixed mode always favours m0, round-robin favours the other master
      if (mode)
        grant = 2'b01;
      else
        grant = (last_grant == M0) ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between m0 and m1: one command per cycle,
// round-robin or fixed priority, with a timed lock for read-modify-write.
module onchip_memory_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ARB_MODE     = ARB_RR,
  parameter int LOCK_TIMEOUT = 16,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_lock,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_lock,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic [1:0]       req;
  logic [1:0]       req_elig;
  logic [1:0]       grant;
  master_id_t       last_grant;
  master_id_t       lock_owner;
  master_id_t       rd_id;
  master_id_t       gnt_id;
  logic             lock_valid;
  logic             rd_pend;
  logic [CNT_W-1:0] idle_cnt;
  logic             accept;
  logic             gnt_write;
  logic             gnt_lock;
  logic             owner_req;

  assign req      = {m1_read | m1_write, m0_read | m0_write};
  assign req_elig = reset ? 2'b00 : req;

  arb2_grant u_grant (
    .req        (req_elig),
    .last_grant (last_grant),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .mode       (ARB_MODE == ARB_FIXED),
    .grant      (grant)
  );

  assign accept    = |grant;
  assign gnt_id    = grant[1] ? M1 : M0;
  assign gnt_write = grant[1] ? m1_write : m0_write;
  assign gnt_lock  = grant[1] ? m1_lock : m0_lock;
  assign owner_req = (lock_owner == M1) ? req[1] : req[0];

  assign mem_address    = grant[1] ? m1_address    : m0_address;
  assign mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
  assign mem_chipselect = accept;
  assign mem_write      = accept & gnt_write;
  assign mem_clken      = ~reset;

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  // Gated by reset so a read accepted just before reset never returns
  assign m0_readdatavalid = rd_pend & ~reset & (rd_id == M0);
  assign m1_readdatavalid = rd_pend & ~reset & (rd_id == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M1;
      lock_valid <= 1'b0;
      lock_owner <= M0;
      idle_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_id      <= M0;
    end else begin
      rd_pend <= accept & ~gnt_write;
      if (accept) begin
        last_grant <= gnt_id;
        rd_id      <= gnt_id;
      end
      // While locked only the owner can be accepted, so an unlocked accept releases
      if (accept && gnt_lock) begin
        lock_valid <= 1'b1;
        lock_owner <= gnt_id;
        idle_cnt   <= '0;
      end else if (accept && lock_valid) begin
        lock_valid <= 1'b0;
        idle_cnt   <= '0;
      end else if (lock_valid && !owner_req) begin
        if (idle_cnt == IDLE_LAST) begin
          lock_valid <= 1'b0;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: a round-robin and a fixed-priority instance
// share stimulus, each with its own RAM and a rule-level reference model.
module tb_onchip_memory_arbiter;

  localparam int LT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;

  logic        w0 [2];
  logic        w1 [2];
  logic        rv0 [2];
  logic        rv1 [2];
  logic        cs [2];
  logic        mw [2];
  logic        ck [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];
  logic [11:0] ma [2];
  logic [3:0]  mbe [2];
  logic [31:0] ram [2][4096];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    onchip_memory_arbiter #(
      .ARB_MODE     (g),
      .LOCK_TIMEOUT (LT),
      .ADDR_W       (12),
      .DATA_W       (32)
    ) dut (
      .clk              (clk),
      .reset            (rst),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_lock          (m0_lock),
      .m0_waitrequest   (w0[g]),
      .m0_readdata      (rd0[g]),
      .m0_readdatavalid (rv0[g]),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_lock          (m1_lock),
      .m1_waitrequest   (w1[g]),
      .m1_readdata      (rd1[g]),
      .m1_readdatavalid (rv1[g]),
      .mem_address      (ma[g]),
      .mem_byteenable   (mbe[g]),
      .mem_chipselect   (cs[g]),
      .mem_write        (mw[g]),
      .mem_writedata    (mwd[g]),
      .mem_clken        (ck[g]),
      .mem_readdata     (mrd[g])
    );

    // Single-port RAM with one-cycle registered read
    always @(posedge clk) begin
      if (ck[g] && cs[g]) begin
        if (mw[g]) begin
          for (int b = 0; b < 4; b++)
            if (mbe[g][b]) ram[g][ma[g]][8*b +: 8] <= mwd[g][8*b +: 8];
        end
        mrd[g] <= ram[g][ma[g]];
      end
    end
  end

  function automatic logic [31:0] pat(input int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 ^ a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state, one set per instance (instance k uses ARB_MODE k)
  int          m_last [2];
  bit          m_lkv [2];
  int          m_lko [2];
  int          m_idle [2];
  bit          m_rp [2];
  int          m_rid [2];
  logic [31:0] m_rdat [2];
  logic [31:0] mm [2][4096];

  logic [1:0]  c_rq;
  int          c_w;
  logic        c_wr, c_lk;
  logic [11:0] c_a;
  logic [31:0] c_d;
  logic [3:0]  c_be;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1; m_lkv[k] = 0; m_lko[k] = 0; m_idle[k] = 0;
      m_rp[k] = 0; m_rid[k] = 0; m_rdat[k] = '0;
      for (int a = 0; a < 4096; a++) begin
        ram[k][a] = pat(a);
        mm[k][a]  = pat(a);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      c_rq = {m1_read | m1_write, m0_read | m0_write};
      c_w = -1;
      if (!rst) begin
        if (m_lkv[k]) begin
          if (c_rq[m_lko[k]]) c_w = m_lko[k];
        end else if (c_rq == 2'b11) begin
          c_w = (k == 1) ? 0 : 1 - m_last[k];
        end else if (c_rq[0]) begin
          c_w = 0;
        end else if (c_rq[1]) begin
          c_w = 1;
        end
      end
      c_wr = (c_w == 1) ? m1_write : m0_write;
      c_lk = (c_w == 1) ? m1_lock : m0_lock;
      c_a  = (c_w == 1) ? m1_address : m0_address;
      c_d  = (c_w == 1) ? m1_writedata : m0_writedata;
      c_be = (c_w == 1) ? m1_byteenable : m0_byteenable;

      chk($sformatf("i%0d_wait0", k), 32'(w0[k]), 32'(c_rq[0] && c_w != 0));
      chk($sformatf("i%0d_wait1", k), 32'(w1[k]), 32'(c_rq[1] && c_w != 1));
      chk($sformatf("i%0d_cs", k), 32'(cs[k]), 32'(c_w >= 0));
      chk($sformatf("i%0d_mwrite", k), 32'(mw[k]), 32'(c_w >= 0 && c_wr));
      chk($sformatf("i%0d_clken", k), 32'(ck[k]), 32'(!rst));
      if (c_w >= 0) chk($sformatf("i%0d_maddr", k), 32'(ma[k]), 32'(c_a));
      if (c_w >= 0 && c_wr) begin
        chk($sformatf("i%0d_mwdata", k), mwd[k], c_d);
        chk($sformatf("i%0d_mbe", k), 32'(mbe[k]), 32'(c_be));
      end
      chk($sformatf("i%0d_rdv0", k), 32'(rv0[k]), 32'(!rst && m_rp[k] && m_rid[k] == 0));
      chk($sformatf("i%0d_rdv1", k), 32'(rv1[k]), 32'(!rst && m_rp[k] && m_rid[k] == 1));
      if (!rst && m_rp[k]) begin
        if (m_rid[k] == 0) chk($sformatf("i%0d_rdata0", k), rd0[k], m_rdat[k]);
        else               chk($sformatf("i%0d_rdata1", k), rd1[k], m_rdat[k]);
      end

      if (rst) begin
        m_last[k] = 1; m_lkv[k] = 0; m_idle[k] = 0; m_rp[k] = 0;
      end else begin
        m_rp[k] = (c_w >= 0) && !c_wr;
        if (c_w >= 0) begin
          m_last[k] = c_w;
          if (c_wr) begin
            for (int b = 0; b < 4; b++)
              if (c_be[b]) mm[k][c_a][8*b +: 8] = c_d[8*b +: 8];
          end else begin
            m_rid[k]  = c_w;
            m_rdat[k] = mm[k][c_a];
          end
        end
        if (c_w >= 0 && c_lk) begin
          m_lkv[k] = 1; m_lko[k] = c_w; m_idle[k] = 0;
        end else if (c_w >= 0 && m_lkv[k]) begin
          m_lkv[k] = 0; m_idle[k] = 0;
        end else if (m_lkv[k] && !c_rq[m_lko[k]]) begin
          m_idle[k]++;
          if (m_idle[k] >= LT) begin
            m_lkv[k] = 0; m_idle[k] = 0;
          end
        end else begin
          m_idle[k] = 0;
        end
      end
    end
  end

  task automatic set0(input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic lk);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    m0_byteenable = be; m0_lock = lk;
  endtask

  task automatic set1(input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic lk);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    m1_byteenable = be; m1_lock = lk;
  endtask

  task automatic idle_all();
    set0(0, 0, '0, '0, '0, 0);
    set1(0, 0, '0, '0, '0, 0);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    set0(1, 0, 12'h000, '0, 4'hF, 0);
    settle();
    chk("rst_wait0", 32'(w0[0]), 32'd1);
    chk("rst_cs", 32'(cs[0]), 32'd0);
    chk("rst_clken", 32'(ck[0]), 32'd0);
    tick(); tick();

    rst = 1'b0;
    idle_all();
    set1(1, 0, 12'h010, '0, 4'hF, 0);
    settle();
    chk("single_wait1", 32'(w1[0]), 32'd0);
    tick();
    idle_all();
    settle();
    chk("single_rdv1", 32'(rv1[0]), 32'd1);
    chk("single_rdata1", rd1[0], 32'hDEADBEEF);
    chk("single_rdv0", 32'(rv0[0]), 32'd0);
    tick();

    for (int i = 0; i < 6; i++) begin
      set0(1, 0, 12'(12'h100 + i), '0, 4'hF, 0);
      set1(1, 0, 12'(12'h200 + i), '0, 4'hF, 0);
      settle();
      chk("rr_wait0", 32'(w0[0]), 32'(i % 2));
      chk("rr_wait1", 32'(w1[0]), 32'((i % 2) == 0));
      chk("fix_wait0", 32'(w0[1]), 32'd0);
      chk("fix_wait1", 32'(w1[1]), 32'd1);
      if (i > 0) chk("rr_rdv0", 32'(rv0[0]), 32'(i % 2));
      tick();
    end
    idle_all();
    tick();

    set0(0, 1, 12'h030, 32'h11223344, 4'hF, 0); settle(); tick();
    set0(1, 0, 12'h030, '0, 4'hF, 0); settle(); tick();
    set0(0, 1, 12'h030, 32'hAABBCCDD, 4'b0101, 0);
    settle();
    chk("wr_rd_rdv0", 32'(rv0[0]), 32'd1);
    chk("wr_rd_data", rd0[0], 32'h11223344);
    tick();
    set0(1, 0, 12'h030, '0, 4'hF, 0); settle(); tick();
    set0(1, 1, 12'h031, 32'h01020304, 4'hF, 0);
    settle();
    chk("partial_data", rd0[0], 32'h11BB33DD);
    tick();
    idle_all();
    settle();
    chk("rdwr_drop_rdv0", 32'(rv0[0]), 32'd0);
    tick();

    set0(1, 0, 12'h040, '0, 4'hF, 0);
    set1(0, 1, 12'h020, 32'hCAFEF00D, 4'hF, 1);
    settle();
    chk("lock_take_wait1", 32'(w1[0]), 32'd0);
    chk("lock_take_wait0", 32'(w0[0]), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set1(0, 0, '0, '0, '0, 0);
      settle();
      chk("lock_hold_wait0", 32'(w0[0]), 32'd1);
      tick();
    end
    set1(0, 1, 12'h020, 32'h12345678, 4'hF, 0);
    settle();
    chk("unlock_wait1", 32'(w1[0]), 32'd0);
    chk("unlock_wait0", 32'(w0[0]), 32'd1);
    tick();
    set1(0, 0, '0, '0, '0, 0);
    settle();
    chk("after_unlock_wait0", 32'(w0[0]), 32'd0);
    tick();
    idle_all();
    tick();

    set0(0, 1, 12'h050, 32'h0BADF00D, 4'hF, 1);
    settle(); tick();
    for (int i = 1; i <= 5; i++) begin
      set0(0, 0, '0, '0, '0, 0);
      set1(1, 0, 12'h060, '0, 4'hF, 0);
      settle();
      chk("timeout_wait1_rr", 32'(w1[0]), 32'(i <= LT));
      chk("timeout_wait1_fix", 32'(w1[1]), 32'(i <= LT));
      tick();
    end
    idle_all();
    tick();

    set0(1, 0, 12'h030, '0, 4'hF, 0);
    settle(); tick();
    rst = 1'b1;
    set1(1, 0, 12'h060, '0, 4'hF, 0);
    settle();
    chk("rstmid_rdv0", 32'(rv0[0]), 32'd0);
    chk("rstmid_cs", 32'(cs[0]), 32'd0);
    chk("rstmid_wait1", 32'(w1[0]), 32'd1);
    tick();
    rst = 1'b0;
    settle();
    chk("rstrel_wait0", 32'(w0[0]), 32'd0);
    chk("rstrel_wait1", 32'(w1[0]), 32'd1);
    chk("rstrel_rdv0", 32'(rv0[0]), 32'd0);
    tick();

    for (int i = 0; i < 60; i++) begin
      set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           12'(12'h300 + $urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7) == 0));
      set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           12'(12'h300 + $urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7) == 0));
      settle(); tick();
    end
    idle_all();
    tick(); tick(); tick(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
